ifu_fetch_ctrl: RTL

//  Instruction-fetch sequencer in front of the 4 KB instruction memory. Owns the PC and issues
//  one word fetch at a time to the IM. Presents the fetched word to decode through a valid/ready

---
 rtl/ifu_fetch_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one IM fetch in flight, applies redirects; PC_RANGE_CHECK_EN adds fetch_err.
// Latency: inst_valid rises 2 cycles after im_req with a 1-cycle IM; accepted instructions every 3 cycles.
// Backpressure: inst/inst_pc held in HOLD until inst_ready; no fetch is issued meanwhile.
module ifu_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        im_rvalid,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic [1:0]  redir_type,
  input  logic [31:0] redir_pc,
  input  logic [15:0] redir_imm16,
  input  logic [25:0] redir_imm26,
  input  logic [31:0] redir_reg,
  input  logic        halt,
  output logic        halted
`ifdef PC_RANGE_CHECK_EN
  ,
  output logic        fetch_err
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        drop, drop_n;
  logic        hpend, hpend_n;
  logic        cap;
  logic        redir;
  logic [31:0] seq_pc, tgt;

`ifdef PC_RANGE_CHECK_EN
  localparam logic [32:0] PC_LO = {1'b0, PC_RESET};
  localparam logic [32:0] PC_HI = PC_LO + 33'(IM_DEPTH) * 33'd4;
  logic err_n;

  function automatic logic pc_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} < PC_LO) || ({1'b0, a} >= PC_HI);
  endfunction
`endif

  assign redir = |redir_type;

  always_comb begin
    seq_pc = redir_pc + 32'd4;
    case (redir_type)
      2'b01:   tgt = seq_pc + {{14{redir_imm16[15]}}, redir_imm16, 2'b00};
      2'b10:   tgt = {seq_pc[31:28], redir_imm26, 2'b00};
      default: tgt = redir_reg;
    endcase
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    hpend_n = hpend;
    cap     = 1'b0;
`ifdef PC_RANGE_CHECK_EN
    err_n   = fetch_err;
`endif
    case (state)
      S_IDLE: begin
        if (halt) state_n = S_HALT;
        else begin
          state_n = S_REQ;
          if (redir) pc_n = tgt;
        end
      end
      S_REQ: begin
        // The strobe has already gone out for the old pc, so a redirect here must drop its response.
        if (halt) state_n = S_HALT;
        else begin
          state_n = S_WAIT;
          if (redir) begin
            pc_n   = tgt;
            drop_n = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (halt) hpend_n = 1'b1;
        else if (redir && !hpend) pc_n = tgt;
        if (im_rvalid) begin
          drop_n  = 1'b0;
          hpend_n = 1'b0;
          if (halt || hpend) state_n = S_HALT;
          else if (!drop && !redir) begin
            cap     = 1'b1;
            state_n = S_HOLD;
          end else state_n = S_REQ;
        end else if (redir && !halt && !hpend) drop_n = 1'b1;
      end
      S_HOLD: begin
        if (halt) state_n = S_HALT;
        else if (redir) begin
          pc_n    = tgt;
          state_n = S_REQ;
        end else if (inst_ready) begin
          pc_n    = pc + 32'd4;
          state_n = S_REQ;
        end
      end
      default: state_n = S_HALT;
    endcase
`ifdef PC_RANGE_CHECK_EN
    // A bad pc never reaches the IM: park instead of entering REQ.
    if (state_n == S_REQ && pc_bad(pc_n)) begin
      state_n = S_HALT;
      err_n   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= PC_RESET;
      drop       <= 1'b0;
      hpend      <= 1'b0;
      im_req     <= 1'b0;
      im_addr    <= PC_RESET;
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
      halted     <= 1'b0;
`ifdef PC_RANGE_CHECK_EN
      fetch_err  <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      drop       <= drop_n;
      hpend      <= hpend_n;
      im_req     <= (state_n == S_REQ);
      if (state_n == S_REQ) im_addr <= pc_n;
      inst_valid <= (state_n == S_HOLD);
      halted     <= (state_n == S_HALT);
      if (cap) begin
        inst    <= im_rdata;
        inst_pc <= pc;
      end
`ifdef PC_RANGE_CHECK_EN
      fetch_err  <= err_n;
`endif
    end
  end

endmodule
